approx_adder_error_meter: RTL and testbench

Exhaustive error-characterisation engine for the parameterised approximate ripple-carry adder family. On `start` it sweeps every operand pair of a WIDTH-bit adder, compares the approximate sum against the exact sum, and accumulates worst-case error, error count and squared-error sum. It is the measurement end of the approximate-adder flow: it consumes adder outputs and produces the metrics (WCE, ER, MSE numerator) the team uses to rank adder variants.

---
 rtl/approx_eval_pkg.sv | 42 ++++
 rtl/approx_adder_error_meter_if.sv | 38 +++
 rtl/approx_rca.sv | 28 ++
 rtl/approx_adder_error_meter.sv | 158 +++++++++++++++
 tb/tb_approx_adder_error_meter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_eval_pkg.sv
// Shared FSM encodings, pipeline constants and width helpers for the
// approximate-adder error meter.
package approx_eval_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Cycles spent flushing the two-stage error pipeline after the last pair.
  localparam int unsigned DrainLen  = 2;
  localparam int unsigned DrainCntW = (DrainLen > 1) ? $clog2(DrainLen) : 1;

  function automatic int unsigned sum_w(input int unsigned w);
    return w + 1;
  endfunction

  function automatic int unsigned err_w(input int unsigned w);
    return w + 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned sqr_w(input int unsigned w);
    return 2 * w + 2;
  endfunction

  function automatic int unsigned count_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

  function automatic int unsigned sq_sum_w(input int unsigned w);
    return 4 * w + 2;
  endfunction

  function automatic int unsigned bias_w(input int unsigned w);
    return 3 * w + 2;
  endfunction

endpackage

// File: rtl/approx_adder_error_meter_if.sv
// Control and metric bundle of the error meter; bias_sum exists only when
// APPROX_EVAL_ERR_BIAS_EN is defined.
interface approx_adder_error_meter_if #(
  parameter int unsigned WIDTH = 8
);
  import approx_eval_pkg::*;

  logic                             start;
  logic                             busy;
  logic                             done;
  logic [sum_w(WIDTH)-1:0]          wce;
  logic [count_w(WIDTH)-1:0]        err_count;
  logic [sq_sum_w(WIDTH)-1:0]       sq_err_sum;
`ifdef APPROX_EVAL_ERR_BIAS_EN
  logic signed [bias_w(WIDTH)-1:0]  bias_sum;

  modport master (
    output start,
    input  busy, done, wce, err_count, sq_err_sum, bias_sum
  );

  modport slave (
    input  start,
    output busy, done, wce, err_count, sq_err_sum, bias_sum
  );
`else
  modport master (
    output start,
    input  busy, done, wce, err_count, sq_err_sum
  );

  modport slave (
    input  start,
    output busy, done, wce, err_count, sq_err_sum
  );
`endif

endinterface

// File: rtl/approx_rca.sv
// Combinational ripple-carry adder whose APPROX_LSBS low positions use the
// approximate cell (S = Y & Z, Cout = X | ~Z); upper positions are exact.
module approx_rca #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_LSBS = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  always_comb begin : p_chain
    logic carry;
    carry = 1'b0;
    sum_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < APPROX_LSBS) begin
        sum_o[i] = b_i[i] & carry;
        carry    = a_i[i] | ~carry;
      end else begin
        sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
        carry    = (a_i[i] & b_i[i]) | (a_i[i] & carry) | (b_i[i] & carry);
      end
    end
    sum_o[WIDTH] = carry;
  end

endmodule

// File: rtl/approx_adder_error_meter.sv
// Exhaustive sweep of every operand pair through approx_rca versus an exact adder,
// accumulating WCE, error count and squared-error sum (bias sum with APPROX_EVAL_ERR_BIAS_EN).
module approx_adder_error_meter
  import approx_eval_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_LSBS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  approx_adder_error_meter_if.slave   m_if
);

  localparam int unsigned SumW   = sum_w(WIDTH);
  localparam int unsigned ErrW   = err_w(WIDTH);
  localparam int unsigned CntW   = cnt_w(WIDTH);
  localparam int unsigned SqrW   = sqr_w(WIDTH);
  localparam int unsigned CountW = count_w(WIDTH);
  localparam int unsigned SqW    = sq_sum_w(WIDTH);

  logic [1:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DrainCntW-1:0] drain_q, drain_d;
  logic                 clear;

  logic                 v1_q;
  logic signed [ErrW-1:0] err_q, err_d;

  logic [SumW-1:0]      wce_q, wce_d;
  logic [CountW-1:0]    count_q, count_d;
  logic [SqW-1:0]       sq_q, sq_d;

  logic [WIDTH-1:0]     op_a, op_b;
  logic [SumW-1:0]      approx_sum, exact_sum;
  logic [SumW-1:0]      err_abs;
  logic [SqrW-1:0]      err_sq;

  assign op_a = cnt_q[CntW-1:WIDTH];
  assign op_b = cnt_q[WIDTH-1:0];

  approx_rca #(
    .WIDTH       (WIDTH),
    .APPROX_LSBS (APPROX_LSBS)
  ) u_rca (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (approx_sum)
  );

  assign exact_sum = {1'b0, op_a} + {1'b0, op_b};
  assign err_d     = $signed({1'b0, approx_sum}) - $signed({1'b0, exact_sum});

  // |err| never exceeds 2^(WIDTH+1)-1, so the top bit of the negation is dropped.
  assign err_abs = SumW'(err_q[ErrW-1] ? -err_q : err_q);
  assign err_sq  = SqrW'(err_abs) * SqrW'(err_abs);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      StIdle: begin
        if (m_if.start) begin
          state_d = StSweep;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      StSweep: begin
        if (cnt_q == '1) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainCntW'(DrainLen - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wce_d   = wce_q;
    count_d = count_q;
    sq_d    = sq_q;
    if (clear) begin
      wce_d   = '0;
      count_d = '0;
      sq_d    = '0;
    end else if (v1_q) begin
      if (err_abs > wce_q) wce_d = err_abs;
      if (err_q != '0)     count_d = count_q + 1'b1;
      sq_d = sq_q + SqW'(err_sq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      v1_q    <= 1'b0;
      err_q   <= '0;
      wce_q   <= '0;
      count_q <= '0;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      v1_q    <= (state_q == StSweep);
      err_q   <= err_d;
      wce_q   <= wce_d;
      count_q <= count_d;
      sq_q    <= sq_d;
    end
  end

`ifdef APPROX_EVAL_ERR_BIAS_EN
  localparam int unsigned BiasW = bias_w(WIDTH);

  logic signed [BiasW-1:0] bias_q, bias_d;

  always_comb begin
    bias_d = bias_q;
    if (clear) begin
      bias_d = '0;
    end else if (v1_q) begin
      bias_d = bias_q + {{(BiasW - ErrW){err_q[ErrW-1]}}, err_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '0;
    end else begin
      bias_q <= bias_d;
    end
  end

  assign m_if.bias_sum = bias_q;
`endif

  assign m_if.busy       = (state_q == StSweep) || (state_q == StDrain);
  assign m_if.done       = (state_q == StDone);
  assign m_if.wce        = wce_q;
  assign m_if.err_count  = count_q;
  assign m_if.sq_err_sum = sq_q;

endmodule

// File: tb/tb_approx_adder_error_meter.sv
// Bench for approx_adder_error_meter: a 2-bit/1-approx-LSB meter and an 8-bit exact meter,
// expected metrics queued at start and compared on done.
module tb_approx_adder_error_meter;

  localparam int unsigned SW = 2;
  localparam int unsigned SK = 1;
  localparam int unsigned WW = 8;
  localparam int unsigned WK = 0;

  typedef struct {
    longint wce;
    longint cnt;
    longint sq;
    longint bias;
  } metrics_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  approx_adder_error_meter_if #(.WIDTH(SW)) s_if ();
  approx_adder_error_meter_if #(.WIDTH(WW)) w_if ();

  approx_adder_error_meter #(.WIDTH(SW), .APPROX_LSBS(SK)) u_dut_s (
    .clk  (clk),
    .rst  (rst),
    .m_if (s_if.slave)
  );

  approx_adder_error_meter #(.WIDTH(WW), .APPROX_LSBS(WK)) u_dut_w (
    .clk  (clk),
    .rst  (rst),
    .m_if (w_if.slave)
  );

  metrics_t sb_s[$];
  metrics_t sb_w[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Error of the 2-bit adder is 2 - a0 - b0, so: wce 2, 12 nonzero, sum sq 24, sum 16.
  localparam metrics_t ExpSmall = '{wce: 2, cnt: 12, sq: 24, bias: 16};
  localparam metrics_t ExpWide  = '{wce: 0, cnt: 0, sq: 0, bias: 0};

  function automatic metrics_t rd_s();
    metrics_t m;
    m.wce = longint'(s_if.wce);
    m.cnt = longint'(s_if.err_count);
    m.sq  = longint'(s_if.sq_err_sum);
`ifdef APPROX_EVAL_ERR_BIAS_EN
    m.bias = longint'(s_if.bias_sum);
`else
    m.bias = 0;
`endif
    return m;
  endfunction

  function automatic metrics_t rd_w();
    metrics_t m;
    m.wce = longint'(w_if.wce);
    m.cnt = longint'(w_if.err_count);
    m.sq  = longint'(w_if.sq_err_sum);
`ifdef APPROX_EVAL_ERR_BIAS_EN
    m.bias = longint'(w_if.bias_sum);
`else
    m.bias = 0;
`endif
    return m;
  endfunction

  // Runs one sweep on the small meter; lat is edges from accept to done (-1 on timeout).
  task automatic run_s(input int pulse_at, input bit pulse_done, output int lat,
                       output bit busy_ok, output bit idle_ok);
    lat = -1;
    busy_ok = 1'b1;
    idle_ok = 1'b1;
    @(negedge clk);
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    if (s_if.busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      s_if.start = (k == pulse_at);
      @(posedge clk);
      #1;
      if (s_if.done === 1'b1) begin
        lat = k;
        if (s_if.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (s_if.busy !== 1'b1) busy_ok = 1'b0;
    end
    s_if.start = 1'b0;
    if (lat >= 0) begin
      if (pulse_done) s_if.start = 1'b1;
      for (int k = 0; k < 2; k++) begin
        @(posedge clk);
        #1;
        s_if.start = 1'b0;
        if (s_if.done !== 1'b0 || s_if.busy !== 1'b0) idle_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    s_if.start = 1'b0;
    w_if.start = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_if.busy, s_if.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_s_ctrl: got busy/done %b want 00", {s_if.busy, s_if.done});
    end
    n_cmp++;
    if (s_if.wce !== '0 || s_if.err_count !== '0 || s_if.sq_err_sum !== '0) begin
      n_fail++; $display("FAIL reset_s_metrics: got %0d/%0d/%0d want 0/0/0",
                         s_if.wce, s_if.err_count, s_if.sq_err_sum);
    end
    n_cmp++;
    if ({w_if.busy, w_if.done} !== 2'b00 || w_if.wce !== '0 || w_if.err_count !== '0
        || w_if.sq_err_sum !== '0) begin
      n_fail++; $display("FAIL reset_w: got busy %b done %b wce %0d cnt %0d sq %0d want all 0",
                         w_if.busy, w_if.done, w_if.wce, w_if.err_count, w_if.sq_err_sum);
    end
`ifdef APPROX_EVAL_ERR_BIAS_EN
    n_cmp++;
    if (s_if.bias_sum !== '0) begin
      n_fail++; $display("FAIL reset_bias: got %0d want 0", s_if.bias_sum);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep_small(input string tag, input int pulse_at, input bit pulse_done);
    int lat;
    bit busy_ok, idle_ok;
    metrics_t exp_m, act;
    sb_s.push_back(ExpSmall);
    run_s(pulse_at, pulse_done, lat, busy_ok, idle_ok);
    act = rd_s();
    n_cmp++;
    if (lat !== 18) begin
      n_fail++; $display("FAIL %s latency: got %0d want 18", tag, lat);
    end
    n_cmp++;
    if (!busy_ok || !idle_ok) begin
      n_fail++; $display("FAIL %s busy/done shape: got busy_ok %0b idle_ok %0b want 1 1",
                         tag, busy_ok, idle_ok);
    end
    if (sb_s.size() == 0) begin
      n_cmp++; n_fail++; $display("FAIL %s scoreboard: got empty queue want 1 entry", tag);
    end else begin
      exp_m = sb_s.pop_front();
      n_cmp++;
      if (act.wce !== exp_m.wce) begin
        n_fail++; $display("FAIL %s wce: got %0d want %0d", tag, act.wce, exp_m.wce);
      end
      n_cmp++;
      if (act.cnt !== exp_m.cnt) begin
        n_fail++; $display("FAIL %s err_count: got %0d want %0d", tag, act.cnt, exp_m.cnt);
      end
      n_cmp++;
      if (act.sq !== exp_m.sq) begin
        n_fail++; $display("FAIL %s sq_err_sum: got %0d want %0d", tag, act.sq, exp_m.sq);
      end
`ifdef APPROX_EVAL_ERR_BIAS_EN
      n_cmp++;
      if (act.bias !== exp_m.bias) begin
        n_fail++; $display("FAIL %s bias_sum: got %0d want %0d", tag, act.bias, exp_m.bias);
      end
`endif
    end
  endtask

  task automatic test_exact_wide();
    int lat;
    metrics_t exp_m, act;
    lat = -1;
    sb_w.push_back(ExpWide);
    @(negedge clk);
    w_if.start = 1'b1;
    @(posedge clk);
    #1;
    w_if.start = 1'b0;
    for (int k = 1; k <= 70000; k++) begin
      @(posedge clk);
      #1;
      if (w_if.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    act = rd_w();
    n_cmp++;
    if (lat !== 65538) begin
      n_fail++; $display("FAIL wide latency: got %0d want 65538", lat);
    end
    exp_m = sb_w.pop_front();
    n_cmp++;
    if (act.wce !== exp_m.wce || act.cnt !== exp_m.cnt || act.sq !== exp_m.sq
        || act.bias !== exp_m.bias) begin
      n_fail++; $display("FAIL wide metrics: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         act.wce, act.cnt, act.sq, act.bias,
                         exp_m.wce, exp_m.cnt, exp_m.sq, exp_m.bias);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    sb_s.push_back(ExpSmall);
    @(negedge clk);
    s_if.start = 1'b1;
    @(posedge clk);
    #1;
    s_if.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    sb_s.delete();
    #1;
    n_cmp++;
    if ({s_if.busy, s_if.done} !== 2'b00 || s_if.wce !== '0 || s_if.err_count !== '0
        || s_if.sq_err_sum !== '0) begin
      n_fail++; $display("FAIL mid_reset: got busy %b done %b wce %0d cnt %0d sq %0d want all 0",
                         s_if.busy, s_if.done, s_if.wce, s_if.err_count, s_if.sq_err_sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (s_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_idle: got busy %b want 0", s_if.busy);
    end
    test_sweep_small("after_reset", -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    metrics_t act;
    test_sweep_small("b2b_first", -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    act = rd_s();
    n_cmp++;
    if (act.wce !== ExpSmall.wce || act.cnt !== ExpSmall.cnt || act.sq !== ExpSmall.sq) begin
      n_fail++; $display("FAIL hold_in_idle: got %0d/%0d/%0d want %0d/%0d/%0d",
                         act.wce, act.cnt, act.sq, ExpSmall.wce, ExpSmall.cnt, ExpSmall.sq);
    end
    test_sweep_small("b2b_second", -1, 1'b0);
  endtask

  initial begin
    s_if.start = 1'b0;
    w_if.start = 1'b0;
    test_reset();
    test_sweep_small("sweep", -1, 1'b0);
    test_exact_wide();
    test_reset_mid();
    test_sweep_small("start_ignored", 3, 1'b1);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
